// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// valid/ack byte handshake with framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FRQ   = 27000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CYCLE = CLK_FRQ / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);
  localparam logic [15:0] HALF_LAST  = 16'(HALF - 1);

  generate
    if (CYCLE < 4) begin : g_cycle_check
      $error("uart_rx: CLK_FRQ / BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_sync1, r_sync2;
  logic [15:0] r_cycle_cnt, w_cycle_cnt_next;
  logic [3:0]  r_bit_cnt, w_bit_cnt_next;
  logic [7:0]  r_shreg, w_shreg_next;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid, r_frame_err, r_overrun;
  logic        w_rx_sync, w_byte_done, w_frame_err;

  assign w_rx_sync = r_sync2;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cycle_cnt <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cycle_cnt <= w_cycle_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shreg     <= w_shreg_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_cycle_cnt_next = r_cycle_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_shreg_next     = r_shreg;
    w_byte_done      = 1'b0;
    w_frame_err      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_sync) begin
          w_cycle_cnt_next = '0;
          w_state_next     = S_START;
        end
      end

      S_START: begin
        w_cycle_cnt_next = r_cycle_cnt + 16'd1;
        if (r_cycle_cnt == HALF_LAST) begin
          if (!w_rx_sync) begin
            w_cycle_cnt_next = '0;
            w_bit_cnt_next   = '0;
            w_state_next     = S_DATA;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end

      S_DATA: begin
        w_cycle_cnt_next = r_cycle_cnt + 16'd1;
        if (r_cycle_cnt == CYCLE_LAST) begin
          w_shreg_next     = {w_rx_sync, r_shreg[7:1]};
          w_cycle_cnt_next = '0;
          w_bit_cnt_next   = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) w_state_next = S_STOP;
        end
      end

      S_STOP: begin
        w_cycle_cnt_next = r_cycle_cnt + 16'd1;
        if (r_cycle_cnt == CYCLE_LAST) begin
          w_cycle_cnt_next = '0;
          if (w_rx_sync) begin
            w_byte_done  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Hold off until the line returns high so a break never looks like a start.
        if (w_rx_sync) w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // A completing byte takes priority over a same-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_byte_done & r_rx_valid & ~rx_ack;
      if (w_byte_done) begin
        r_rx_data  <= r_shreg;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;
  assign rx_busy      = (r_state != S_IDLE);

endmodule
